// File: rtl/lsu_bus_master.sv
// lsu_bus_master: initiator side of the data-memory interface. Takes one
// decoded load/store from the EXU, runs it as a request/response transaction
// on a variable-latency memory port and hands the result to the WBU.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   req_*               EXU operation (valid/ready, store flag, funct3, addr, wdata)
//   mem_req_*, mem_*    bus request channel (word address, write enable, lane data, mask)
//   mem_rsp_*           bus response / write-ack channel
//   done_*              result to WBU (extended load data, error flag)
//
// Errors (misaligned, illegal funct3, response timeout) complete through DONE
// with done_err=1 and done_rdata=0. Illegal or misaligned requests never reach
// the bus.
module lsu_bus_master #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [DATA_WIDTH-1:0] done_rdata,
  output logic                  done_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wmask_q, mem_wmask_d;
  logic [DATA_WIDTH-1:0] done_rdata_q, done_rdata_d;
  logic                  done_err_q, done_err_d;

  logic                  req_legal;
  logic [3:0]            req_mask;
  logic [DATA_WIDTH-1:0] rsp_shifted;
  logic [DATA_WIDTH-1:0] load_data;

  // Request decode: legality (size code, store-only-signed, alignment) and lane mask.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      3'b000:  req_legal = 1'b1;
      3'b001:  req_legal = ~req_addr[0];
      3'b010:  req_legal = (req_addr[1:0] == 2'b00);
      3'b100:  req_legal = ~req_is_store;
      3'b101:  req_legal = ~req_is_store & ~req_addr[0];
      default: req_legal = 1'b0;
    endcase

    req_mask = 4'b1111;
    case (req_funct3[1:0])
      2'b00:   req_mask = 4'b0001 << req_addr[1:0];
      2'b01:   req_mask = 4'b0011 << req_addr[1:0];
      default: req_mask = 4'b1111;
    endcase
  end

  // Load extraction from the captured byte offset and size code.
  always_comb begin
    rsp_shifted = mem_rsp_rdata >> {addr_lo_q, 3'b000};
    load_data   = rsp_shifted;
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, rsp_shifted[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, rsp_shifted[15:0]};
      default: load_data = rsp_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    mem_addr_d   = mem_addr_q;
    mem_wen_d    = mem_wen_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    done_rdata_d = done_rdata_q;
    done_err_d   = done_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d   = req_is_store;
          funct3_d     = req_funct3;
          addr_lo_d    = req_addr[1:0];
          done_rdata_d = '0;
          if (!req_legal) begin
            state_d    = DONE;
            done_err_d = 1'b1;
          end else begin
            state_d     = REQ;
            done_err_d  = 1'b0;
            mem_addr_d  = {req_addr[DATA_WIDTH-1:2], 2'b00};
            mem_wen_d   = req_is_store;
            mem_wdata_d = req_wdata << {req_addr[1:0], 3'b000};
            mem_wmask_d = req_is_store ? req_mask : 4'b0000;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        // A response in the final timeout cycle still wins.
        if (mem_rsp_valid) begin
          state_d      = DONE;
          done_err_d   = 1'b0;
          done_rdata_d = is_store_q ? '0 : load_data;
        end else if (cnt_q == CNT_MAX) begin
          state_d      = DONE;
          done_err_d   = 1'b1;
          done_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      done_rdata_q <= '0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      mem_addr_q   <= mem_addr_d;
      mem_wen_q    <= mem_wen_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      done_rdata_q <= done_rdata_d;
      done_err_q   <= done_err_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_rsp_ready = (state_q == RESP);
  assign done_valid    = (state_q == DONE);
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign done_rdata    = done_rdata_q;
  assign done_err      = done_err_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Testbench for lsu_bus_master: directed and random loads/stores against a
// behavioural reference model; a monitor compares bus requests and results
// with scoreboard queues filled at stimulus time.
module tb_lsu_bus_master;

  localparam int unsigned T = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        done_valid, done_ready;
  logic [31:0] done_rdata;
  logic        done_err;

  always #5 clk = ~clk;

  lsu_bus_master #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
    .done_valid(done_valid), .done_ready(done_ready), .done_rdata(done_rdata), .done_err(done_err)
  );

  typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask; } bus_t;
  typedef struct { logic [31:0] rdata; logic err; } done_t;
  typedef struct { int unsigned req_dly; int unsigned rsp_dly; logic [31:0] rdata; bit ignored; } rsp_t;

  bus_t  bus_q[$];
  done_t done_q[$];
  rsp_t  rsp_q[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic stop_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  // Reference model: access size from funct3, natural alignment, byte lanes.
  function automatic void model(input bit st, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, input bit [31:0] rd, input bit no_rsp,
                                output bit legal, output bus_t b, output done_t d);
    int unsigned size, off;
    bit sgn;
    longint v;
    off = a % 4;
    case (f3)
      3'd0:    begin size = 1; sgn = 1; legal = 1;   end
      3'd1:    begin size = 2; sgn = 1; legal = 1;   end
      3'd2:    begin size = 4; sgn = 0; legal = 1;   end
      3'd4:    begin size = 1; sgn = 0; legal = !st; end
      3'd5:    begin size = 2; sgn = 0; legal = !st; end
      default: begin size = 1; sgn = 0; legal = 0;   end
    endcase
    if (a % size != 0) legal = 0;
    b.addr  = a - off;
    b.wen   = st;
    b.wdata = 32'(longint'(wd) << (8 * off));
    b.wmask = st ? 4'(((1 << size) - 1) << off) : 4'd0;
    d.err   = 1'b0;
    d.rdata = '0;
    if (!legal || no_rsp) begin
      d.err = 1'b1;
    end else if (!st) begin
      v = (longint'(rd) >> (8 * off)) % (longint'(1) << (8 * size));
      if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
      d.rdata = 32'(v);
    end
  endfunction

  // Monitor: every cycle a request/result is presented it must match the queue head.
  always @(negedge clk) begin
    if (mem_req_valid) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 32'(mem_req_valid), 32'd0);
      end else begin
        chk("mem_addr",  mem_addr,         bus_q[0].addr);
        chk("mem_wen",   32'(mem_wen),     32'(bus_q[0].wen));
        chk("mem_wdata", mem_wdata,        bus_q[0].wdata);
        chk("mem_wmask", 32'(mem_wmask),   32'(bus_q[0].wmask));
        if (mem_req_ready) void'(bus_q.pop_front());
      end
    end
    if (done_valid) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 32'(done_valid), 32'd0);
      end else begin
        chk("done_rdata", done_rdata,     done_q[0].rdata);
        chk("done_err",   32'(done_err),  32'(done_q[0].err));
        if (done_ready) void'(done_q.pop_front());
      end
    end
  end

  // Responder: per-transaction request stall, response delay and data.
  initial begin : responder
    rsp_t r;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req_valid && rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        repeat (r.req_dly) begin @(posedge clk); #1; end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        repeat (r.rsp_dly) begin @(posedge clk); #1; end
        if (r.ignored) chk("late_rsp_ready", 32'(mem_rsp_ready), 32'd0);
        else           chk("rsp_ready",      32'(mem_rsp_ready), 32'd1);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = r.rdata;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"},     32'(req_ready),     32'd1);
    chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_mem_rsp_ready"}, 32'(mem_rsp_ready), 32'd0);
    chk({tag, "_done_valid"},    32'(done_valid),    32'd0);
    chk({tag, "_done_err"},      32'(done_err),      32'd0);
    chk({tag, "_done_rdata"},    done_rdata,         32'd0);
    chk({tag, "_mem_addr"},      mem_addr,           32'd0);
    chk({tag, "_mem_wdata"},     mem_wdata,          32'd0);
    chk({tag, "_mem_wmask"},     32'(mem_wmask),     32'd0);
    chk({tag, "_mem_wen"},       32'(mem_wen),       32'd0);
  endtask

  task automatic run_txn(input bit st, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit [31:0] rd,
                         input int unsigned req_dly, input int unsigned rsp_dly,
                         input bit no_rsp, input int unsigned done_dly);
    bit legal;
    bus_t b;
    done_t d;
    rsp_t r;
    int unsigned exp_lat, k;
    model(st, f3, a, wd, rd, no_rsp, legal, b, d);
    if (legal) begin
      bus_q.push_back(b);
      r.req_dly = req_dly;
      r.rsp_dly = no_rsp ? T + 5 : rsp_dly;
      r.rdata   = rd;
      r.ignored = no_rsp;
      rsp_q.push_back(r);
    end
    done_q.push_back(d);
    exp_lat = !legal ? 1 : (no_rsp ? 2 + req_dly + T : 3 + req_dly + rsp_dly);

    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (!req_ready) stop_now("accept_wait");
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom); req_is_store = 1'($urandom);
    k = 1;
    while (!done_valid && k < 200) begin @(posedge clk); #1; k++; end
    if (!done_valid) stop_now("done_wait");
    chk("latency", k, exp_lat);
    repeat (done_dly) begin @(posedge clk); #1; end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    if (no_rsp) repeat (10) begin @(posedge clk); #1; end
  endtask

  // Store abandoned by reset while waiting in RESP; its late response must be ignored.
  task automatic reset_mid_txn();
    bit legal;
    bus_t b;
    done_t d;
    rsp_t r;
    model(1'b1, 3'd2, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0, 1'b0, legal, b, d);
    bus_q.push_back(b);
    r.req_dly = 0; r.rsp_dly = 8; r.rdata = 32'h1234_5678; r.ignored = 1'b1;
    rsp_q.push_back(r);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h0000_1234; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk_reset("mid_rst");
    repeat (15) begin @(posedge clk); #1; end
    chk("post_rst_done_valid", 32'(done_valid), 32'd0);
  endtask

  initial begin : watchdog
    #900000;
    stop_now("global_watchdog");
  end

  initial begin : driver
    bit st;
    bit [2:0] f3;
    bit [31:0] a;
    int unsigned pick;
    rst = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; done_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0, 0);   // lb
    run_txn(1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h80FF_1234, 0, 0, 1'b0, 0);   // lhu
    run_txn(1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'h80FF_1234, 1, 2, 1'b0, 1);   // lh
    run_txn(1'b1, 3'd0, 32'h8000_0001, 32'hAB, 32'h5555_5555, 0, 0, 1'b0, 0);  // sb
    run_txn(1'b1, 3'd2, 32'h8000_0002, 32'h1, 32'h0, 0, 0, 1'b0, 0);           // sw misaligned
    run_txn(1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1'b0, 0);           // funct3 011
    run_txn(1'b1, 3'd4, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1'b0, 1);           // store with bu
    run_txn(1'b1, 3'd1, 32'h8000_0003, 32'h0, 32'h0, 0, 0, 1'b0, 0);           // sh misaligned
    run_txn(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 5, 10, 1'b0, 3);  // stalled lw
    run_txn(1'b0, 3'd4, 32'h8000_0021, 32'h0, 32'h0000_9A00, 0, T - 1, 1'b0, 0); // rsp on last cycle
    run_txn(1'b0, 3'd2, 32'h8000_0040, 32'h0, 32'h0, 2, 0, 1'b1, 2);           // timeout
    run_txn(1'b1, 3'd1, 32'h8000_0042, 32'hFFFF_BEEF, 32'h0, 0, 1, 1'b0, 0);   // sh upper half

    reset_mid_txn();

    for (int i = 0; i < 150; i++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        pick = $urandom_range(0, 4);
        f3 = (pick == 3) ? 3'd4 : (pick == 4) ? 3'd5 : 3'(pick);
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      run_txn(st, f3, a, $urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, T - 1),
              ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (5) begin @(posedge clk); #1; end
    chk("bus_q_left",  bus_q.size(),  32'd0);
    chk("done_q_left", done_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Initiator side of the data-memory interface: turns one decoded load/store from the EXU into a request/response transaction on a variable-latency memory port.
- Replaces the zero-latency combinational LSU path to memory.
- Aligns store data and generates byte masks.
- Extracts and sign/zero-extends load data.
- Flags misaligned accesses, illegal sizes and response timeouts.
- Sits between EXU/LSU decode and the memory responder; its result goes to WBU.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum number of cycles to wait in RESP for mem_rsp_valid before reporting a bus error. Must be at least 1.

Ports:
- clk  in  1  clock; all logic samples on its rising edge.
- rst  in  1  reset, synchronous, active-low; the block is reset when rst=0 at a rising edge of clk.
- req_valid  in  1  EXU offers a memory operation.
- req_ready  out  1  block accepts the operation.
- req_is_store  in  1  1=store, 0=load.
- req_funct3  in  3  size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  responder accepts the request.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wen  out  1  1=write.
- mem_wdata  out  32  lane-shifted store data.
- mem_wmask  out  4  byte-lane write mask.
- mem_rsp_valid  in  1  response or write-ack valid.
- mem_rsp_ready  out  1  block accepts the response.
- mem_rsp_rdata  in  32  read word.
- done_valid  out  1  result available.
- done_ready  in  1  WBU consumes the result.
- done_rdata  out  32  extended load data; 0 for stores.
- done_err  out  1  misaligned access, illegal funct3, or timeout.

Behaviour:
- States: IDLE, REQ, RESP, DONE.
- Reset (rst=0 at a clock edge):
  - State goes to IDLE and the timeout counter clears.
  - req_ready=1 (it follows IDLE); mem_req_valid, mem_rsp_ready, done_valid, done_err = 0; done_rdata = 0.
  - mem_addr, mem_wdata, mem_wmask, mem_wen = 0.
  - A reset mid-transaction abandons the transaction.
  - A response that arrives after reset is ignored.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture is_store, funct3, addr and wdata.
  - Illegal funct3 (011, 110, 111; and 100/101 with is_store=1) or a misaligned access (h/hu with addr[0]=1; w with addr[1:0]≠0): go to DONE with done_err=1 and issue no bus transaction.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1.
  - mem_addr, mem_wen, mem_wdata and mem_wmask are registered at accept and held stable until mem_req_ready.
  - mem_wdata = wdata << 8*addr[1:0].
  - mem_wmask: b = 0001<<addr[1:0]; h = 0011<<addr[1:0]; w = 1111. For loads mem_wmask=0000.
  - On mem_req_ready=1 go to RESP, with the counter cleared.
- RESP:
  - mem_rsp_ready=1.
  - On mem_rsp_valid, go to DONE with done_err=0.
  - For a load, done_rdata is formed by shifting rsp_rdata right by 8*addr[1:0], then sign-extending from bit 7/15 (b/h) or zero-extending (bu/hu); w passes through.
  - For a store, the response is only an ack and done_rdata=0.
  - Each cycle without a response increments the counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with no response, go to DONE with done_err=1 and done_rdata=0.
  - If the response and the timeout coincide in the same cycle, the response wins.
- DONE:
  - done_valid=1; done_rdata and done_err are held stable until done_ready.
  - On done_ready, go to IDLE.
  - A new request is accepted no earlier than the next cycle in IDLE.
- mem_rsp_ready=0 outside RESP; any mem_rsp_valid there is ignored.
- Minimum latency, accept to done_valid: 3 cycles with mem_req_ready and mem_rsp_valid both immediate. An error path takes 1 cycle.
- Only one transaction is outstanding at a time.

Test Plan:
- lb, addr=0x80000003, rsp_rdata=0x80FF1234 -> mem_addr=0x80000000, mem_wmask=0000, done_rdata=0xFFFFFF80, done_err=0.
- lhu, addr=0x80000002, rsp_rdata=0x80FF1234 -> done_rdata=0x000080FF. Same with lh -> 0xFFFF80FF.
- sb, addr=0x80000001, wdata=0x000000AB -> mem_wdata=0x0000AB00, mem_wmask=0010, mem_wen=1. After ack, done_rdata=0, done_err=0.
- sw, addr=0x80000002 -> no mem_req_valid, done_valid one cycle after accept, done_err=1. funct3=011 -> same result.
- mem_req_ready held low 5 cycles, then high; mem_rsp delayed 10 cycles -> bus outputs stable throughout; done_valid appears the cycle after rsp. done_ready held low 3 cycles -> outputs held.
- TIMEOUT_CYCLES=4 with no rsp -> done_err=1 after 4 RESP cycles; a late rsp in IDLE is ignored. rst=0 in RESP -> IDLE next edge, all valids 0.
